// File: rtl/fpadd_pkg.sv
// Shared fpadd definitions: datapath widths and the normalizer FSM state type.
package fpadd_pkg;

  localparam int unsigned SIG_W  = 64;
  localparam int unsigned EXP_W  = 12;
  localparam int unsigned OEXP_W = 13;
  localparam int unsigned SHW    = 7;
  localparam int unsigned KW     = 3;
  localparam int unsigned CNT_W  = 6;

  localparam logic [KW-1:0] K_START = KW'(5);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_normalize_seq_norm_step.sv
// One normalization step: if the top 2^k bits are zero, shift left by 2^k.
module norm_step
  import fpadd_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic [KW-1:0]    k,
  output logic [SIG_W-1:0] shifted_c,
  output logic             hit_c
);

  logic [CNT_W-1:0] amt;

  assign amt = CNT_W'(1) << k;

  always_comb begin
    hit_c = 1'b0;
    case (k)
      3'd5:    hit_c = (sig[63:32] == '0);
      3'd4:    hit_c = (sig[63:48] == '0);
      3'd3:    hit_c = (sig[63:56] == '0);
      3'd2:    hit_c = (sig[63:60] == '0);
      3'd1:    hit_c = (sig[63:62] == '0);
      3'd0:    hit_c = ~sig[63];
      default: hit_c = 1'b0;
    endcase
    shifted_c = hit_c ? (sig << amt) : sig;
  end

endmodule

// File: rtl/fp_normalize_seq.sv
// Sequential leading-zero normalizer: six binary-search shift steps (32..1) per operand.
module fp_normalize_seq
  import fpadd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIG_W-1:0]  in_sig,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIG_W-1:0]  out_sig,
  output logic [OEXP_W-1:0] out_exp,
  output logic [SHW-1:0]    out_shift,
  output logic              out_zero
);

  state_t            state, state_d;
  logic [KW-1:0]     k, k_d;
  logic [SIG_W-1:0]  work, work_d;
  logic [EXP_W-1:0]  exp_r, exp_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              in_ready_d, out_valid_d, out_zero_d;
  logic [SIG_W-1:0]  out_sig_d;
  logic [OEXP_W-1:0] out_exp_d;
  logic [SHW-1:0]    out_shift_d;

  logic [SIG_W-1:0]  step_sig;
  logic              step_hit;

  norm_step u_norm_step (
    .sig       (work),
    .k         (k),
    .shifted_c (step_sig),
    .hit_c     (step_hit)
  );

  // Next-state and next-output logic; result registers load only on the final step.
  always_comb begin
    state_d     = state;
    k_d         = k;
    work_d      = work;
    exp_d       = exp_r;
    cnt_d       = cnt;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_sig_d   = out_sig;
    out_exp_d   = out_exp;
    out_shift_d = out_shift;
    out_zero_d  = out_zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_d     = in_sig;
          exp_d      = in_exp;
          k_d        = K_START;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_sig;
        if (step_hit) cnt_d = cnt | (CNT_W'(1) << k);
        k_d = k - KW'(1);
        if (k == '0) begin
          state_d     = DONE;
          k_d         = K_START;
          out_valid_d = 1'b1;
          if (step_sig == '0) begin
            // All-zero significand: report a full-width shift and a zero exponent.
            out_zero_d  = 1'b1;
            out_sig_d   = '0;
            out_shift_d = SHW'(SIG_W);
            out_exp_d   = '0;
          end else begin
            out_zero_d  = 1'b0;
            out_sig_d   = step_sig;
            out_shift_d = SHW'(cnt_d);
            out_exp_d   = OEXP_W'(exp_r) - OEXP_W'(cnt_d);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= K_START;
      work      <= '0;
      exp_r     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sig   <= '0;
      out_exp   <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      work      <= work_d;
      exp_r     <= exp_d;
      cnt       <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_sig   <= out_sig_d;
      out_exp   <= out_exp_d;
      out_shift <= out_shift_d;
      out_zero  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Directed self-checking bench for fp_normalize_seq with hand-computed expectations.
module tb_fp_normalize_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sig;
  logic [11:0] in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sig;
  logic [12:0] out_exp;
  logic [6:0]  out_shift;
  logic        out_zero;

  int n_tests = 0;
  int n_fail  = 0;

  fp_normalize_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sig    (in_sig),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sig   (out_sig),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Issue one operand, measure latency, check the result, hold for 'hold' cycles, then handshake.
  task automatic run_op(input string tag, input logic [63:0] sig, input logic [11:0] e,
                        input logic [63:0] xs, input logic [12:0] xe, input logic [6:0] xsh,
                        input logic xz, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_sig   = sig;
    in_exp   = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sig   = {$urandom, $urandom};
    in_exp   = 12'($urandom);
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      in_sig = {$urandom, $urandom};
    end
    check({tag, "_lat"}, 64'(lat), 64'd6);
    check({tag, "_sig"}, out_sig, xs);
    check({tag, "_exp"}, 64'(out_exp), 64'(xe));
    check({tag, "_shift"}, 64'(out_shift), 64'(xsh));
    check({tag, "_zero"}, 64'(out_zero), 64'(xz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_sig"}, out_sig, xs);
      check({tag, "_hold_exp"}, 64'(out_exp), 64'(xe));
      check({tag, "_hold_shift"}, 64'(out_shift), 64'(xsh));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_vld"}, 64'(out_valid), 64'd0);
    check({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sig    = '0;
    in_exp    = '0;
    #12;
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_sig", out_sig, 64'd0);
    check("rst_exp", 64'(out_exp), 64'd0);
    check("rst_shift", 64'(out_shift), 64'd0);
    check("rst_zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("msb",  64'h8000_0000_0000_0000, 12'd1023, 64'h8000_0000_0000_0000, 13'd1023, 7'd0,  1'b0, 0);
    run_op("one",  64'h1,                   12'd1023, 64'h8000_0000_0000_0000, 13'd960,  7'd63, 1'b0, 5);
    run_op("zero", 64'h0,                   12'd500,  64'h0,                   13'd0,    7'd64, 1'b1, 0);
    run_op("f0",   64'h0000_0000_00F0_0000, 12'd10,   64'hF000_0000_0000_0000, 13'h1FE2, 7'd40, 1'b0, 0);
    run_op("b31",  64'h0000_0001_0000_0000, 12'd100,  64'h8000_0000_0000_0000, 13'd69,   7'd31, 1'b0, 2);
    run_op("b62",  64'h4000_0000_0000_0000, 12'd0,    64'h8000_0000_0000_0000, 13'h1FFF, 7'd1,  1'b0, 0);
    run_op("mix",  64'h0123_4567_89AB_CDEF, 12'd2000, 64'h91A2_B3C4_D5E6_F780, 13'd1993, 7'd7,  1'b0, 0);
    run_op("neg",  64'h1,                   12'd0,    64'h8000_0000_0000_0000, 13'h1FC1, 7'd63, 1'b0, 0);

    // Abort an operation with reset while the k=3 step is pending.
    @(negedge clk);
    in_valid = 1'b1;
    in_sig   = 64'h0000_0000_0000_00FF;
    in_exp   = 12'd77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("abort_vld", 64'(out_valid), 64'd0);
    check("abort_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("abort_no_out", 64'(seen), 64'd0);
      check("abort_rdy_after", 64'(in_ready), 64'd1);
    end
    run_op("after", 64'h1, 12'd1023, 64'h8000_0000_0000_0000, 13'd960, 7'd63, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
